// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: opcodes, functs,
// ALU function codes, ALU-op classes and FSM state codes.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOP_NONE is the idle class: it yields function code 000 in states that
   // do not use the ALU, so those states drive all-zero outputs.
   typedef enum logic [1:0] {
      ALUOP_NONE  = 2'b00,
      ALUOP_ADD   = 2'b01,
      ALUOP_SUB   = 2'b10,
      ALUOP_FUNCT = 2'b11
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

endpackage

// File: rtl/alu_dec.sv
// ALU function decoder: maps the ALU-op class and R-type funct onto the 3-bit
// ALU function code, and flags whether the funct is one we support.
module alu_dec
   import mc_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_func_o,
   output logic       funct_valid_o
);

   logic [2:0] funct_code;

   always_comb begin
      funct_code    = ALU_AND;
      funct_valid_o = 1'b1;
      case (funct_i)
         FN_ADD:  funct_code = ALU_ADD;
         FN_SUB:  funct_code = ALU_SUB;
         FN_AND:  funct_code = ALU_AND;
         FN_OR:   funct_code = ALU_OR;
         FN_SLT:  funct_code = ALU_SLT;
         default: funct_valid_o = 1'b0;
      endcase
   end

   always_comb begin
      alu_func_o = ALU_AND;
      case (aluop_i)
         ALUOP_ADD:   alu_func_o = ALU_ADD;
         ALUOP_SUB:   alu_func_o = ALU_SUB;
         ALUOP_FUNCT: alu_func_o = funct_code;
         default:     alu_func_o = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore state sequence driving datapath
// enables, mux selects and the ALU function, with a req/ready memory handshake.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_mem_req,
   output logic       o_mem_write,
   output logic       o_iord,
   output logic       o_ir_write,
   output logic       o_pc_en,
   output logic [1:0] o_pc_src,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [2:0] o_alu_func,
   output logic       o_reg_write,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
   output logic       o_illegal
);

   // Memory handshake: o_mem_req is held for as long as the access is pending;
   // the access completes in the cycle where o_mem_req and i_mem_ready are both 1.

   state_t state_q, state_d;
   aluop_t aluop;
   logic   pcwrite;
   logic   branch;
   logic   funct_valid;

   alu_dec u_alu_dec (
      .aluop_i       (aluop),
      .funct_i       (i_funct),
      .alu_func_o    (o_alu_func),
      .funct_valid_o (funct_valid)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d      = S_FETCH;
      aluop        = ALUOP_NONE;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_write  = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_src     = 2'b00;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_reg_write  = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            o_mem_req   = 1'b1;
            o_alu_src_b = 2'b01;
            aluop       = ALUOP_ADD;
            o_ir_write  = i_mem_ready;
            pcwrite     = i_mem_ready;
            state_d     = i_mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            o_alu_src_b = 2'b11;
            aluop       = ALUOP_ADD;
            case (i_op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  state_d   = funct_valid ? S_EXECUTE : S_FETCH;
                  o_illegal = !funct_valid;
               end
               default:      o_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            aluop       = ALUOP_ADD;
            state_d     = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            o_mem_req = 1'b1;
            o_iord    = 1'b1;
            state_d   = i_mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            o_mem_to_reg = 1'b1;
            o_reg_write  = 1'b1;
         end
         S_MEMWR: begin
            o_mem_req   = 1'b1;
            o_iord      = 1'b1;
            o_mem_write = 1'b1;
            state_d     = i_mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            o_alu_src_a = 1'b1;
            aluop       = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            o_reg_dst   = 1'b1;
            o_reg_write = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a = 1'b1;
            aluop       = ALUOP_SUB;
            o_pc_src    = 2'b01;
            branch      = 1'b1;
         end
         S_ADDIEX: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            aluop       = ALUOP_ADD;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: o_reg_write = 1'b1;
         S_JUMP: begin
            o_pc_src = 2'b10;
            pcwrite  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // In reset the outputs look like an idle FETCH with every enable off, so
      // an instruction interrupted mid-flight cannot complete a write.
      if (!i_rstn) begin
         aluop        = ALUOP_ADD;
         pcwrite      = 1'b0;
         branch       = 1'b0;
         o_mem_req    = 1'b0;
         o_mem_write  = 1'b0;
         o_iord       = 1'b0;
         o_ir_write   = 1'b0;
         o_pc_src     = 2'b00;
         o_alu_src_a  = 1'b0;
         o_alu_src_b  = 2'b01;
         o_reg_write  = 1'b0;
         o_reg_dst    = 1'b0;
         o_mem_to_reg = 1'b0;
         o_illegal    = 1'b0;
      end
   end

   assign o_pc_en = pcwrite | (branch & i_zero);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table of inputs and expected
// outputs, plus a hand-written lw sequence with memory wait states.
module tb_mc_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rstn;
   logic [5:0] i_op;
   logic [5:0] i_funct;
   logic       i_zero;
   logic       i_mem_ready;
   logic       o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_en;
   logic [1:0] o_pc_src;
   logic       o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic [2:0] o_alu_func;
   logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal;

   int checks = 0;
   int errors = 0;

   mc_ctrl dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_op         (i_op),
      .i_funct      (i_funct),
      .i_zero       (i_zero),
      .i_mem_ready  (i_mem_ready),
      .o_mem_req    (o_mem_req),
      .o_mem_write  (o_mem_write),
      .o_iord       (o_iord),
      .o_ir_write   (o_ir_write),
      .o_pc_en      (o_pc_en),
      .o_pc_src     (o_pc_src),
      .o_alu_src_a  (o_alu_src_a),
      .o_alu_src_b  (o_alu_src_b),
      .o_alu_func   (o_alu_func),
      .o_reg_write  (o_reg_write),
      .o_reg_dst    (o_reg_dst),
      .o_mem_to_reg (o_mem_to_reg),
      .o_illegal    (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // Packed output order: req wr iord irw pcen pcsrc[2] srca srcb[2] func[3] rw dst m2r ill
   localparam logic [16:0] E_RST   = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
   localparam logic [16:0] E_FETCH = {5'b10011, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
   localparam logic [16:0] E_FWAIT = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
   localparam logic [16:0] E_DEC   = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0000};
   localparam logic [16:0] E_DECI  = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0001};
   localparam logic [16:0] E_MADR  = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
   localparam logic [16:0] E_MRD   = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
   localparam logic [16:0] E_MWB   = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1010};
   localparam logic [16:0] E_MWR   = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000};
   localparam logic [16:0] E_ALUWB = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1100};
   localparam logic [16:0] E_BR1   = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
   localparam logic [16:0] E_BR0   = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
   localparam logic [16:0] E_AIEX  = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
   localparam logic [16:0] E_AIWB  = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1000};
   localparam logic [16:0] E_JMP   = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000};

   function automatic logic [16:0] e_exec(input logic [2:0] f);
      return {5'b00000, 2'b00, 1'b1, 2'b00, f, 4'b0000};
   endfunction

   typedef struct {
      logic        rstn;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        ready;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic rstn, input logic [5:0] op, input logic [5:0] funct,
                          input logic zero, input logic ready, input logic [16:0] exp);
      vec_t v;
      v.rstn = rstn; v.op = op; v.funct = funct; v.zero = zero; v.ready = ready; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic add_rtype(input logic [5:0] funct, input logic [2:0] f);
      add_vec(1, 6'b000000, funct, 1, 1, E_FETCH);
      add_vec(1, 6'b000000, funct, 1, 1, E_DEC);
      add_vec(1, 6'b000000, funct, 1, 1, e_exec(f));
      add_vec(1, 6'b000000, funct, 1, 1, E_ALUWB);
   endtask

   function automatic logic [16:0] dut_outs();
      return {o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_en, o_pc_src,
              o_alu_src_a, o_alu_src_b, o_alu_func,
              o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] rdy_pat;
      int req_cnt, wr_cnt, wb_cyc;

      i_rstn = 1'b0; i_op = 6'b100011; i_funct = '0; i_zero = 1'b0; i_mem_ready = 1'b1;

      for (int i = 0; i < 3; i++) add_vec(0, 6'b100011, 6'd0, 0, 1, E_RST);
      // lw, ready always high
      add_vec(1, 6'b100011, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b100011, 6'd0, 0, 1, E_DEC);
      add_vec(1, 6'b100011, 6'd0, 0, 1, E_MADR);
      add_vec(1, 6'b100011, 6'd0, 0, 1, E_MRD);
      add_vec(1, 6'b100011, 6'd0, 0, 1, E_MWB);
      // addi with one fetch wait cycle
      add_vec(1, 6'b001000, 6'd0, 0, 0, E_FWAIT);
      add_vec(1, 6'b001000, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b001000, 6'd0, 0, 1, E_DEC);
      add_vec(1, 6'b001000, 6'd0, 0, 1, E_AIEX);
      add_vec(1, 6'b001000, 6'd0, 0, 1, E_AIWB);
      // sw, two wait cycles in MEMWR
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_DEC);
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_MADR);
      add_vec(1, 6'b101011, 6'd0, 0, 0, E_MWR);
      add_vec(1, 6'b101011, 6'd0, 0, 0, E_MWR);
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_MWR);
      // R-type functs
      add_rtype(6'b101010, 3'b111);
      add_rtype(6'b100010, 3'b110);
      add_rtype(6'b100000, 3'b010);
      add_rtype(6'b100100, 3'b000);
      add_rtype(6'b100101, 3'b001);
      // beq taken / not taken
      add_vec(1, 6'b000100, 6'd0, 1, 1, E_FETCH);
      add_vec(1, 6'b000100, 6'd0, 1, 1, E_DEC);
      add_vec(1, 6'b000100, 6'd0, 1, 1, E_BR1);
      add_vec(1, 6'b000100, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b000100, 6'd0, 0, 1, E_DEC);
      add_vec(1, 6'b000100, 6'd0, 0, 1, E_BR0);
      // illegal opcode, then illegal funct
      add_vec(1, 6'b111111, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b111111, 6'd0, 0, 1, E_DECI);
      add_vec(1, 6'b000000, 6'b000111, 0, 1, E_FETCH);
      add_vec(1, 6'b000000, 6'b000111, 0, 1, E_DECI);
      // reset asserted during MEMWR
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_FETCH);
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_DEC);
      add_vec(1, 6'b101011, 6'd0, 0, 1, E_MADR);
      add_vec(1, 6'b101011, 6'd0, 0, 0, E_MWR);
      add_vec(0, 6'b101011, 6'd0, 0, 0, E_RST);
      // j, which also confirms the reset returned the FSM to FETCH
      add_vec(1, 6'b000010, 6'd0, 1, 1, E_FETCH);
      add_vec(1, 6'b000010, 6'd0, 1, 1, E_DEC);
      add_vec(1, 6'b000010, 6'd0, 1, 1, E_JMP);

      for (int i = 0; i < vecs.size(); i++) begin
         i_rstn = vecs[i].rstn; i_op = vecs[i].op; i_funct = vecs[i].funct;
         i_zero = vecs[i].zero; i_mem_ready = vecs[i].ready;
         #1;
         check($sformatf("vec%0d", i), {15'd0, dut_outs()}, {15'd0, vecs[i].exp});
         @(posedge i_clk);
         @(negedge i_clk);
      end

      // lw with two fetch waits and three MEMRD waits: 5 + 5 cycles
      rdy_pat = 10'b1100011100;
      req_cnt = 0; wr_cnt = 0; wb_cyc = -1;
      i_rstn = 1'b1; i_op = 6'b100011; i_funct = '0; i_zero = 1'b0;
      for (int c = 0; c < 10; c++) begin
         i_mem_ready = rdy_pat[c];
         #1;
         if (o_mem_req) req_cnt++;
         if (o_mem_write) wr_cnt++;
         if (o_reg_write && wb_cyc < 0) wb_cyc = c;
         @(posedge i_clk);
         @(negedge i_clk);
      end
      i_mem_ready = 1'b1;
      #1;
      check("lw_wait_req_cycles", req_cnt, 7);
      check("lw_wait_no_write", wr_cnt, 0);
      check("lw_wait_wb_cycle", wb_cyc, 9);
      check("lw_wait_back_fetch", {29'd0, o_mem_req, o_iord, o_ir_write}, 32'b101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle MIPS-subset control unit; it is the driving side of the 3-bit ALU function interface. It decodes opcode/funct into a Moore state sequence and drives datapath enables, mux selects and `o_alu_func` to the ALU. It takes the ALU zero flag back for branches. It handshakes with a single shared instruction/data memory via req/ready.

Parameters:
none (opcode, funct and ALU encodings are fixed constants in the shared package)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset: one clock; reset is synchronous and active-low
- i_op  in  6  instruction opcode (IR[31:26])
- i_funct  in  6  R-type funct (IR[5:0])
- i_zero  in  1  ALU result == 0
- i_mem_ready  in  1  memory completes current access this cycle
- o_mem_req  out  1  memory access request
- o_mem_write  out  1  memory write enable
- o_iord  out  1  address mux: 0=PC, 1=ALUOut
- o_ir_write  out  1  instruction register load
- o_pc_en  out  1  PC load = pcwrite | (branch & i_zero)
- o_pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- o_alu_src_a  out  1  0=PC, 1=regA
- o_alu_src_b  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
- o_alu_func  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- o_reg_write  out  1  register file write enable
- o_reg_dst  out  1  0=rt, 1=rd
- o_mem_to_reg  out  1  0=ALUOut, 1=memory data
- o_illegal  out  1  one-cycle pulse on an unsupported opcode/funct

Behaviour:
- State register is 4 bits. Outputs are Moore-decoded from state, except:
  - `o_pc_en` uses `i_zero`.
  - FETCH and memory-state enables are qualified by `i_mem_ready`.
  - `o_alu_func` decodes from aluop plus `i_funct`.
- Any output not listed for a state is 0.
- While `i_rstn`==0: the state loads FETCH on the clock edge. `o_pc_en`, `o_ir_write`, `o_reg_write`, `o_mem_write`, `o_mem_req` and `o_illegal` are forced 0 combinationally. All other outputs hold their FETCH values: `o_alu_src_b`=01, `o_alu_func`=010, everything else 0.
- Reset mid-instruction abandons it. No partial write completes after the reset edge.
- States and transitions:
  - FETCH: mem_req=1, iord=0, src_a=0, src_b=01, add. When i_mem_ready: ir_write=1, pcwrite=1, go to DECODE. Otherwise stay with no enables.
  - DECODE: src_a=0, src_b=11, add (precomputes branch target). Next state by op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXECUTE if funct supported
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else -> FETCH with o_illegal=1 this cycle
  - MEMADR: src_a=1, src_b=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, iord=1. Stay until i_mem_ready, then MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR: mem_req=1, iord=1, mem_write=1 held every cycle until i_mem_ready, then FETCH.
  - EXECUTE: src_a=1, src_b=00, func from funct -> ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
  - BRANCH: src_a=1, src_b=00, sub, pc_src=01, branch=1 -> FETCH.
  - ADDIEX: src_a=1, src_b=10, add -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
  - JUMP: pc_src=10, pcwrite=1 -> FETCH.
- Funct map: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Any other funct with op=000000 is illegal and handled in DECODE as above.
- Unused state codes (12-15) -> FETCH next cycle, all enables 0.
- Latency with i_mem_ready=1 throughout:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi 4 cycles
  - beq 3 cycles
  - j 3 cycles
- Each wait cycle on ready adds 1 cycle.

Decomposition:
- Package mc_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU function codes: ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111
  - 2-bit aluop codes
  - state encodings S_FETCH=0 .. S_JUMP=11
- One sub-module, alu_dec: combinational (aluop, funct) -> alu_func plus funct_valid. mc_ctrl holds the FSM and output decode.

Test Plan:
- Reset: hold i_rstn=0 for 3 clocks with op=100011 -> all enables 0. After release, FETCH with o_mem_req=1, o_alu_func=010, o_alu_src_b=01.
- lw, i_mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB shows o_reg_write=1 and o_mem_to_reg=1, then back to FETCH.
- sw with i_mem_ready low for 2 cycles in MEMWR -> o_mem_write=1 for 3 consecutive cycles, then FETCH. o_reg_write never asserts.
- R-type funct=101010 -> o_alu_func=111 in EXECUTE, o_reg_dst=1 and o_reg_write=1 in ALUWB. With funct=100010 -> 110.
- beq: i_zero=1 -> o_pc_en=1, o_pc_src=01 in BRANCH. Repeat with i_zero=0 -> o_pc_en=0.
- op=111111, and separately op=000000 with funct=000111 -> o_illegal pulses 1 cycle in DECODE, next state FETCH, no reg/mem write. Assert i_rstn=0 during MEMWR -> o_mem_write drops to 0 the same cycle.
